// File: rtl/wb_bus_arbiter.sv
// Two-master, one-slave Wishbone arbiter: whole-cycle grants, round-robin on
// contention, and a watchdog that aborts unacknowledged strobes with ERR.
module wb_bus_arbiter #(
  parameter int unsigned ADDRESS_WIDTH = 24,
  parameter int unsigned TIMEOUT       = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] m0_adr_i,
  input  logic [15:0]              m0_dat_i,
  output logic [15:0]              m0_dat_o,
  input  logic                     m0_cyc_i,
  input  logic                     m0_stb_i,
  input  logic                     m0_we_i,
  output logic                     m0_ack_o,
  output logic                     m0_err_o,
  input  logic [ADDRESS_WIDTH-1:0] m1_adr_i,
  input  logic [15:0]              m1_dat_i,
  output logic [15:0]              m1_dat_o,
  input  logic                     m1_cyc_i,
  input  logic                     m1_stb_i,
  input  logic                     m1_we_i,
  output logic                     m1_ack_o,
  output logic                     m1_err_o,
  output logic [ADDRESS_WIDTH-1:0] s_adr_o,
  output logic [15:0]              s_dat_o,
  input  logic [15:0]              s_dat_i,
  output logic                     s_cyc_o,
  output logic                     s_stb_o,
  output logic                     s_we_o,
  input  logic                     s_ack_i,
  output logic [1:0]               grant_o,
  output logic                     timeout_o
);

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT - 1);

  state_t      state, stateNext;
  logic        owner, ownerNext;
  logic        lastOwner, lastOwnerNext;
  logic [15:0] wdog, wdogNext;
  logic        ownerCyc, ownerStb, ownerWe;
  logic        busy, expire;

  assign ownerCyc = owner ? m1_cyc_i : m0_cyc_i;
  assign ownerStb = owner ? m1_stb_i : m0_stb_i;
  assign ownerWe  = owner ? m1_we_i  : m0_we_i;
  assign busy     = (state == BUSY);
  // An ack on the limit cycle wins over the abort.
  assign expire   = busy && ownerCyc && ownerStb && !s_ack_i && (wdog == WDOG_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      lastOwner <= 1'b1;
      wdog      <= '0;
      timeout_o <= 1'b0;
    end else begin
      state     <= stateNext;
      owner     <= ownerNext;
      lastOwner <= lastOwnerNext;
      wdog      <= wdogNext;
      timeout_o <= expire;
    end
  end

  always_comb begin
    stateNext     = state;
    ownerNext     = owner;
    lastOwnerNext = lastOwner;
    wdogNext      = '0;
    case (state)
      IDLE: begin
        if (m0_cyc_i || m1_cyc_i) begin
          ownerNext     = (m0_cyc_i && m1_cyc_i) ? ~lastOwner : m1_cyc_i;
          lastOwnerNext = ownerNext;
          stateNext     = BUSY;
        end
      end
      BUSY: begin
        if (!ownerCyc) begin
          stateNext = IDLE;
        end else if (expire) begin
          stateNext = ABORT;
        end else if (ownerStb && !s_ack_i) begin
          wdogNext = wdog + 16'd1;
        end
      end
      ABORT: begin
        if (!ownerCyc) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    s_adr_o  = owner ? m1_adr_i : m0_adr_i;
    s_dat_o  = owner ? m1_dat_i : m0_dat_i;
    s_cyc_o  = busy && ownerCyc;
    s_stb_o  = busy && ownerStb;
    s_we_o   = busy && ownerWe;
    m0_dat_o = s_dat_i;
    m1_dat_o = s_dat_i;
    m0_ack_o = busy && !owner && m0_stb_i && s_ack_i;
    m1_ack_o = busy &&  owner && m1_stb_i && s_ack_i;
    m0_err_o = expire && !owner;
    m1_err_o = expire &&  owner;
    grant_o  = (state == IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);
  end

endmodule
